sccb_cfg_sequencer: RTL

SCCB_CFG_SEQUENCER -- requirements
Module: sccb_cfg_sequencer

---
 rtl/sccb_cfg_pkg.sv | 39 +++
 rtl/sccb_cfg_rom.sv | 26 ++
 rtl/sccb_cfg_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared encodings, markers and field widths for the SCCB register-table sequencer.
// No logic of its own; latency not applicable.
// No flow control; users of these types apply their own.
package sccb_cfg_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int ENTRY_W   = ADDR_W + DATA_W;
    localparam int MAX_TABLE = 256;

    localparam logic [ENTRY_W-1:0] END_MARK   = 16'hFFFF;
    localparam logic [ADDR_W-1:0]  DELAY_ADDR = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DELAY = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Entry i lives at bits [i*ENTRY_W +: ENTRY_W]; unused slots hold the end marker.
    localparam logic [ENTRY_W*MAX_TABLE-1:0] DEFAULT_TABLE =
        {{(MAX_TABLE-4){END_MARK}}, END_MARK, 16'h1101, 16'hFE01, 16'h1280};

    // A zero-millisecond delay still occupies one cycle.
    function automatic logic [31:0] delay_cycles(input logic [DATA_W-1:0] ms,
                                                 input logic [31:0]       clk_per_ms);
        delay_cycles = (ms == '0) ? 32'd1 : 32'(ms) * clk_per_ms;
    endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// Register table ROM: index in, {addr,data} entry out.
// Latency: one cycle (registered output).
// No backpressure; a new index may be presented every cycle.
module sccb_cfg_rom
    import sccb_cfg_pkg::*;
#(
    parameter int                             TABLE_LEN  = 64,
    parameter logic [ENTRY_W*MAX_TABLE-1:0]   TABLE_INIT = DEFAULT_TABLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] index,
    output entry_t            entry
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= '0;
        end else if (int'(index) < TABLE_LEN) begin
            entry <= TABLE_INIT[int'(index)*ENTRY_W +: ENTRY_W];
        end else begin
            entry <= END_MARK;
        end
    end

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the register ROM and issues SCCB writes with retry on NACK; SCCB_CFG_DELAY_EN adds delay markers.
// Latency: 3 idle cycles between an ACK and the next request; ROM read is 1 cycle.
// Backpressure: wr_req holds with stable addr/data until wr_ack or wr_nack.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int                           TABLE_LEN  = 64,
    parameter int                           CLK_PER_MS = 50000,
    parameter int                           MAX_RETRY  = 3,
    parameter logic [ENTRY_W*MAX_TABLE-1:0] TABLE_INIT = DEFAULT_TABLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    input  logic              wr_nack,
    output logic [7:0]        index
);

    localparam logic [8:0] TABLE_END   = 9'(TABLE_LEN);
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    state_t     state;
    logic       start_q;
    logic       start_rise;
    logic [8:0] idx_q;
    logic       rom_vld;
    logic [7:0] retry_cnt;
    entry_t     rom_entry;

`ifdef SCCB_CFG_DELAY_EN
    localparam logic [31:0] MS_CYCLES = 32'(CLK_PER_MS);
    logic [31:0] delay_cnt;
`endif

    assign start_rise = start & ~start_q;

    // Index is nine bits so a full 256-entry walk ends without wrapping; display saturates.
    assign index = idx_q[8] ? 8'hFF : idx_q[7:0];

    sccb_cfg_rom #(
        .TABLE_LEN  (TABLE_LEN),
        .TABLE_INIT (TABLE_INIT)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .index (idx_q[7:0]),
        .entry (rom_entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            start_q   <= 1'b1;   // start held high through reset must not look like an edge
            idx_q     <= '0;
            rom_vld   <= 1'b0;
            retry_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wr_req    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
`ifdef SCCB_CFG_DELAY_EN
            delay_cnt <= '0;
`endif
        end else begin
            start_q <= start;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_rise) begin
                        idx_q     <= '0;
                        rom_vld   <= 1'b0;
                        retry_cnt <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (!rom_vld) begin
                        if (idx_q >= TABLE_END) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            rom_vld <= 1'b1;
                        end
                    end else begin
                        rom_vld <= 1'b0;
                        if (rom_entry == END_MARK) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
`ifdef SCCB_CFG_DELAY_EN
                        end else if (rom_entry.addr == DELAY_ADDR) begin
                            delay_cnt <= delay_cycles(rom_entry.data, MS_CYCLES);
                            state     <= ST_DELAY;
`endif
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end

                // ROM output is still addressed by idx_q, so retries reload the same entry.
                ST_ISSUE: begin
                    wr_addr <= rom_entry.addr;
                    wr_data <= rom_entry.data;
                    wr_req  <= 1'b1;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wr_nack) begin
                        wr_req <= 1'b0;
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            state     <= ST_ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            error <= 1'b1;
                            state <= ST_ERR;
                        end
                    end else if (wr_ack) begin
                        wr_req    <= 1'b0;
                        retry_cnt <= '0;
                        idx_q     <= idx_q + 9'd1;
                        state     <= ST_FETCH;
                    end
                end

`ifdef SCCB_CFG_DELAY_EN
                ST_DELAY: begin
                    if (delay_cnt <= 32'd1) begin
                        delay_cnt <= '0;
                        idx_q     <= idx_q + 9'd1;
                        state     <= ST_FETCH;
                    end else begin
                        delay_cnt <= delay_cnt - 32'd1;
                    end
                end
`endif

                default: begin
                    wr_req <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
